apb_module: RTL and testbench

// - APB (AMBA3-style) completer with an internal word-addressed register memory.
// - Sits behind an APB requester or bridge. Accepts single read/write transfers and

---
 rtl/apb_pkg.sv | 10 +
 rtl/apb_mem.sv | 39 +++
 rtl/apb_module.sv | 119 +++++++++++
 tb/tb_apb_module.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default sizes for the APB completer and its register array.
package apb_pkg;

  typedef enum logic {IDLE, ACCESS} apb_state_e;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_MEM_DEPTH  = 64;

endpackage

// File: rtl/apb_mem.sv
// Word-addressed register array: synchronous write, combinational read,
// asynchronous clear; addresses at or beyond MEM_DEPTH read as zero and ignore writes.
module apb_mem #(
  parameter int ADDR_WIDTH = apb_pkg::APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_pkg::APB_DATA_WIDTH,
  parameter int MEM_DEPTH  = apb_pkg::APB_MEM_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rstN,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic                  w_wrInRange;
  logic                  w_rdInRange;

  assign w_wrInRange = {1'b0, i_waddr} < DEPTH;
  assign w_rdInRange = {1'b0, i_raddr} < DEPTH;

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && w_wrInRange) begin
      r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = w_rdInRange ? r_mem[i_raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/apb_module.sv
// APB completer: setup/access FSM with configurable wait states in front of
// the apb_mem register array; PRDATA is registered, PREADY comes from state only.
module apb_module #(
  parameter int ADDR_WIDTH  = apb_pkg::APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = apb_pkg::APB_DATA_WIDTH,
  parameter int MEM_DEPTH   = apb_pkg::APB_MEM_DEPTH,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY
);
  import apb_pkg::*;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  apb_state_e            r_state;
  apb_state_e            w_nextState;
  logic [3:0]            r_cnt;
  logic [3:0]            w_nextCnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [ADDR_WIDTH-1:0] w_rdAddr;
  logic [DATA_WIDTH-1:0] w_memRdata;
  logic                  w_loadRd;
  logic                  w_ready;
  logic                  w_setup;
  logic                  w_access;
  logic                  w_we;

  assign w_setup  = PSEL && !PENABLE;
  assign w_access = PSEL && PENABLE;
  assign w_ready  = (r_state == ACCESS) && (r_cnt == WAIT_CNT);
  assign w_we     = w_ready && w_access && r_write;

  // PRDATA loads on the edge entering the PREADY cycle; with no wait states that is the setup edge, so PADDR is read directly
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_loadRd    = 1'b0;
    w_rdAddr    = r_addr;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_nextState = ACCESS;
          w_nextCnt   = '0;
          w_rdAddr    = PADDR;
          w_loadRd    = !PWRITE && (WAIT_CNT == 4'd0);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else if (w_access) begin
          if (w_ready) begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_cnt + 4'd1;
            w_loadRd  = !r_write && ((r_cnt + 4'd1) == WAIT_CNT);
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_prdata <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (r_state == IDLE && w_setup) begin
        r_addr  <= PADDR;
        r_write <= PWRITE;
        r_wdata <= PWDATA;
      end
      if (w_loadRd) begin
        r_prdata <= w_memRdata;
      end
    end
  end

  apb_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .i_clk  (PCLK),
    .i_rstN (PRESETn),
    .i_we   (w_we),
    .i_waddr(r_addr),
    .i_wdata(r_wdata),
    .i_raddr(w_rdAddr),
    .o_rdata(w_memRdata)
  );

  assign PREADY = w_ready;
  assign PRDATA = r_prdata;

endmodule

// File: tb/tb_apb_module.sv
// Directed bench for apb_module: one instance with no wait states (index 0)
// and one with two wait states (index 1), each on its own APB bus.
module tb_apb_module;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic [1:0]  psel = '0;
  logic [1:0]  penable = '0;
  logic [1:0]  pwrite = '0;
  logic [7:0]  paddr [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic [1:0]  pready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_module #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut0 (
    .PCLK(clk), .PRESETn(rstN), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0])
  );

  apb_module #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(2)) u_dut2 (
    .PCLK(clk), .PRESETn(rstN), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transfer from setup until the PREADY cycle; the completion edge follows the return.
  task automatic applyStimulus(input int d, input logic wr, input logic [7:0] a,
                               input logic [31:0] wd, output logic [31:0] rd, output int cycles);
    int guard;
    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    cycles = 1;
    @(negedge clk);
    penable[d] = 1'b1;
    cycles = 2;
    guard = 0;
    while (pready[d] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      cycles++;
      guard++;
    end
    checkOutput("readySeen", {31'b0, pready[d]}, 32'd1);
    rd = prdata[d];
  endtask

  task automatic busIdle(input int d);
    @(negedge clk);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int cyc;
    paddr[0] = '0; paddr[1] = '0; pwdata[0] = '0; pwdata[1] = '0;

    #3 rstN = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstReady0", {31'b0, pready[0]}, 32'd0);
    checkOutput("rstRdata0", prdata[0], 32'd0);
    checkOutput("rstReady2", {31'b0, pready[1]}, 32'd0);
    checkOutput("rstRdata2", prdata[1], 32'd0);
    rstN = 1'b1;

    applyStimulus(0, 1'b0, 8'h00, 32'h0, rd, cyc);
    checkOutput("rdAddr0", rd, 32'h0000_0000);
    busIdle(0);

    applyStimulus(0, 1'b1, 8'h05, 32'hDEAD_BEEF, rd, cyc);
    checkOutput("wrCycles", 32'(cyc), 32'd2);
    busIdle(0);
    applyStimulus(0, 1'b0, 8'h05, 32'h0, rd, cyc);
    checkOutput("rdCycles", 32'(cyc), 32'd2);
    checkOutput("rdDeadBeef", rd, 32'hDEAD_BEEF);
    busIdle(0);

    applyStimulus(0, 1'b1, 8'h40, 32'h1234_5678, rd, cyc);
    checkOutput("oorWrCycles", 32'(cyc), 32'd2);
    busIdle(0);
    checkOutput("wrKeepsRdata", prdata[0], 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 8'h40, 32'h0, rd, cyc);
    checkOutput("oorRead", rd, 32'h0000_0000);
    busIdle(0);

    applyStimulus(1, 1'b1, 8'h05, 32'hA5A5_A5A5, rd, cyc);
    checkOutput("wsWrCycles", 32'(cyc), 32'd4);
    busIdle(1);
    applyStimulus(1, 1'b0, 8'h05, 32'h0, rd, cyc);
    checkOutput("wsRdCycles", 32'(cyc), 32'd4);
    checkOutput("wsRdData", rd, 32'hA5A5_A5A5);
    busIdle(1);

    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h07; pwdata[1] = 32'hFFFF_0000;
    @(negedge clk);
    penable[1] = 1'b1;
    checkOutput("abortWaitReady", {31'b0, pready[1]}, 32'd0);
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    applyStimulus(1, 1'b0, 8'h07, 32'h0, rd, cyc);
    checkOutput("abortNoWrite", rd, 32'h0000_0000);
    busIdle(1);

    applyStimulus(0, 1'b1, 8'h01, 32'h0000_0001, rd, cyc);
    applyStimulus(0, 1'b1, 8'h02, 32'h0000_0002, rd, cyc);
    checkOutput("b2bCycles", 32'(cyc), 32'd2);
    busIdle(0);
    applyStimulus(0, 1'b0, 8'h01, 32'h0, rd, cyc);
    checkOutput("b2bRd1", rd, 32'h0000_0001);
    applyStimulus(0, 1'b0, 8'h02, 32'h0, rd, cyc);
    checkOutput("b2bRd2", rd, 32'h0000_0002);
    busIdle(0);

    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h03; pwdata[0] = 32'hCAFE_F00D;
    @(negedge clk);
    penable[0] = 1'b1;
    checkOutput("midReadyBefore", {31'b0, pready[0]}, 32'd1);
    #2 rstN = 1'b0;
    #1 checkOutput("midReadyDrop", {31'b0, pready[0]}, 32'd0);
    checkOutput("midRdataClear", prdata[0], 32'd0);
    @(negedge clk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    rstN = 1'b1;
    applyStimulus(0, 1'b0, 8'h03, 32'h0, rd, cyc);
    checkOutput("midWriteLost", rd, 32'h0000_0000);
    busIdle(0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
